// File: rtl/scc_isa_pkg.sv
// SCC ISA constants shared by the fetch pipeline: opcodes, bubble encoding,
// instruction field positions and the IF control state type.
package scc_isa_pkg;

  localparam logic [6:0]  OP_B  = 7'b1100000;
  localparam logic [6:0]  OP_BR = 7'b1100010;
  localparam logic [31:0] NOP   = 32'hC800_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 25;
  localparam int RS_MSB  = 24;
  localparam int RS_LSB  = 20;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } if_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch stage: taken conditional branch, B, BR or
// sequential +4. Purely combinational; stall/reset hold is handled by the caller.
module pc_next_calc #(
  parameter int         ADDR_W = 32,
  parameter int         OFF_W  = 16,
  parameter logic [6:0] OP_B   = scc_isa_pkg::OP_B,
  parameter logic [6:0] OP_BR  = scc_isa_pkg::OP_BR
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [6:0]        i_opcode,
  input  logic [15:0]       i_imm,
  input  logic [ADDR_W-1:0] i_br_reg_data,
  input  logic              i_b_cond,
  input  logic [OFF_W-1:0]  i_b_rel_addr,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_redirect
);

  // Signed word offset -> byte offset at PC width; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_off(input logic signed [OFF_W-1:0] x);
    logic signed [ADDR_W-1:0] ext;
    ext = ADDR_W'(x);
    return ext <<< 2;
  endfunction

  logic signed [OFF_W-1:0] w_imm_off;
  assign w_imm_off = OFF_W'($signed(i_imm));

  always_comb begin
    o_pc_next  = i_pc + ADDR_W'(4);
    o_redirect = 1'b0;
    if (i_b_cond) begin
      o_pc_next  = i_pc + word_off(i_b_rel_addr);
      o_redirect = 1'b1;
    end else if (i_opcode == OP_B) begin
      o_pc_next  = i_pc + word_off(w_imm_off);
      o_redirect = 1'b1;
    end else if (i_opcode == OP_BR) begin
      o_pc_next  = i_br_reg_data + word_off(w_imm_off);
      o_redirect = 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// SCC instruction-fetch stage: owns the PC, registers the IM word into IF/ID,
// resolves B/BR locally and honours EX redirects, ID stalls and reset.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP      = scc_isa_pkg::NOP,
  parameter logic [6:0]        OP_B     = scc_isa_pkg::OP_B,
  parameter logic [6:0]        OP_BR    = scc_isa_pkg::OP_BR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               b_cond,
  input  logic [OFF_W-1:0]   b_rel_addr,
  output logic [4:0]         br_reg_addr,
  input  logic [ADDR_W-1:0]  br_reg_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out
);

  import scc_isa_pkg::*;

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP);

  if_state_t           r_state;
  if_state_t           w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr_p1;
  logic [ADDR_W-1:0]   r_pc_p1;
  logic                r_vld_p1;
  logic [ADDR_W-1:0]   w_pc_next;
  logic                w_redirect;

  assign br_reg_addr = instr_in[RS_MSB:RS_LSB];

  pc_next_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W),
    .OP_B   (OP_B),
    .OP_BR  (OP_BR)
  ) u_pc_next_calc (
    .i_pc          (r_pc),
    .i_opcode      (instr_in[OPC_MSB:OPC_LSB]),
    .i_imm         (instr_in[IMM_MSB:IMM_LSB]),
    .i_br_reg_data (br_reg_data),
    .i_b_cond      (b_cond),
    .i_b_rel_addr  (b_rel_addr),
    .o_pc_next     (w_pc_next),
    .o_redirect    (w_redirect)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_RESET: w_state_next = S_RUN;
      S_RUN,
      S_HOLD:  w_state_next = stall ? S_HOLD : S_RUN;
      default: w_state_next = S_RESET;
    endcase
  end

  // IF/ID boundary: PC update plus registered instruction, its PC and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr_p1 <= NOP_W;
      r_pc_p1    <= '0;
      r_vld_p1   <= 1'b0;
    end else if (r_state == S_RESET) begin
      r_instr_p1 <= NOP_W;
      r_vld_p1   <= 1'b0;
    end else if (b_cond) begin
      r_pc       <= w_pc_next;
      r_instr_p1 <= NOP_W;
      r_vld_p1   <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_pc_next;
      if (w_redirect) begin
        r_instr_p1 <= NOP_W;
        r_vld_p1   <= 1'b0;
      end else begin
        r_instr_p1 <= instr_in;
        r_pc_p1    <= r_pc;
        r_vld_p1   <= 1'b1;
      end
    end
  end

  assign pc              = r_pc;
  assign instruction_out = r_instr_p1;
  assign pc_out          = r_pc_p1;
  assign valid_out       = r_vld_p1;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, B/BR, stall, EX
// redirect priority, reset mid-stall, and PC wrap on an 8-bit instance.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        stall;
  logic        b_cond;
  logic [15:0] b_rel_addr;
  logic [4:0]  br_reg_addr;
  logic [31:0] br_reg_data;
  logic [31:0] pc;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        valid_out;

  logic [4:0]  w8_br_reg_addr;
  logic [7:0]  w8_pc;
  logic [31:0] w8_instruction_out;
  logic [7:0]  w8_pc_out;
  logic        w8_valid_out;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOPV = 32'hC800_0000;
  localparam logic [31:0] I1   = 32'h1111_0001;
  localparam logic [31:0] I2   = 32'h2222_0002;
  localparam logic [31:0] I3   = 32'h3333_0003;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .instr_in        (instr_in),
    .stall           (stall),
    .b_cond          (b_cond),
    .b_rel_addr      (b_rel_addr),
    .br_reg_addr     (br_reg_addr),
    .br_reg_data     (br_reg_data),
    .pc              (pc),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

  if_stage #(.ADDR_W(8), .RESET_PC(8'hFC)) dut_w8 (
    .clk             (clk),
    .rst             (rst),
    .instr_in        (I1),
    .stall           (1'b0),
    .b_cond          (1'b0),
    .b_rel_addr      (16'h0000),
    .br_reg_addr     (w8_br_reg_addr),
    .br_reg_data     (8'h00),
    .pc              (w8_pc),
    .instruction_out (w8_instruction_out),
    .pc_out          (w8_pc_out),
    .valid_out       (w8_valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; b_cond = 1'b0; b_rel_addr = 16'h0;
    instr_in = I1; br_reg_data = 32'h0;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction_out, NOPV);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_valid", valid_out, 1'b0);
    chk("w8_rst_pc", w8_pc, 8'hFC);

    rst = 1'b0;
    tick();
    chk("bubble_valid", valid_out, 1'b0);
    chk("bubble_instr", instruction_out, NOPV);
    chk("bubble_pc_hold", pc, 32'h0);
    chk("w8_bubble_pc", w8_pc, 8'hFC);

    tick();
    chk("seq1_pc", pc, 32'h4);
    chk("seq1_instr", instruction_out, I1);
    chk("seq1_pc_out", pc_out, 32'h0);
    chk("seq1_valid", valid_out, 1'b1);
    chk("w8_wrap_pc", w8_pc, 8'h00);
    chk("w8_wrap_pc_out", w8_pc_out, 8'hFC);
    chk("w8_wrap_valid", w8_valid_out, 1'b1);

    instr_in = I2; tick();
    chk("seq2_pc", pc, 32'h8);
    chk("seq2_pc_out", pc_out, 32'h4);
    chk("seq2_instr", instruction_out, I2);
    instr_in = I3; tick();
    chk("seq3_pc", pc, 32'hC);
    chk("seq3_pc_out", pc_out, 32'h8);

    b_cond = 1'b1; b_rel_addr = 16'd5; tick();
    chk("cond_fwd_pc", pc, 32'h20);
    chk("cond_fwd_valid", valid_out, 1'b0);
    chk("cond_fwd_instr", instruction_out, NOPV);
    b_cond = 1'b0;

    instr_in = 32'hC000_FFFE; tick();
    chk("b_back_pc", pc, 32'h18);
    chk("b_back_valid", valid_out, 1'b0);
    chk("b_back_pc_out", pc_out, 32'h8);
    instr_in = I1; tick();
    chk("after_b_pc", pc, 32'h1C);
    chk("after_b_pc_out", pc_out, 32'h18);
    chk("after_b_valid", valid_out, 1'b1);
    instr_in = I2; tick();
    chk("to_20_pc", pc, 32'h20);
    instr_in = 32'hC000_0003; tick();
    chk("b_fwd_pc", pc, 32'h2C);
    chk("b_fwd_valid", valid_out, 1'b0);

    instr_in = 32'hC450_0002; br_reg_data = 32'h100; #1;
    chk("br_reg_addr", br_reg_addr, 5'd5);
    tick();
    chk("br_pc", pc, 32'h108);
    chk("br_valid", valid_out, 1'b0);
    chk("br_instr", instruction_out, NOPV);

    b_cond = 1'b1; b_rel_addr = 16'hFFCD; instr_in = I1; tick();
    chk("cond_back_pc", pc, 32'h3C);
    b_cond = 1'b0; tick();
    chk("pre_stall_pc", pc, 32'h40);
    chk("pre_stall_valid", valid_out, 1'b1);

    stall = 1'b1; instr_in = I2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h40);
      chk("stall_instr", instruction_out, I1);
      chk("stall_pc_out", pc_out, 32'h3C);
      chk("stall_valid", valid_out, 1'b1);
    end
    stall = 1'b0; tick();
    chk("release_pc", pc, 32'h44);
    chk("release_instr", instruction_out, I2);
    chk("release_pc_out", pc_out, 32'h40);

    instr_in = I3;
    for (int i = 0; i < 3; i++) tick();
    chk("to_50_pc", pc, 32'h50);
    chk("to_50_pc_out", pc_out, 32'h4C);

    b_cond = 1'b1; b_rel_addr = 16'hFFFC; stall = 1'b1; instr_in = 32'hC000_0003;
    tick();
    chk("prio_pc", pc, 32'h40);
    chk("prio_instr", instruction_out, NOPV);
    chk("prio_valid", valid_out, 1'b0);
    chk("prio_pc_out", pc_out, 32'h4C);
    b_cond = 1'b0; tick();
    chk("hold_pc", pc, 32'h40);

    rst = 1'b1; tick();
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", valid_out, 1'b0);
    chk("midrst_pc_out", pc_out, 32'h0);
    chk("midrst_instr", instruction_out, NOPV);
    rst = 1'b0; tick();
    chk("midrst_bubble_pc", pc, 32'h0);
    stall = 1'b0; instr_in = I1; tick();
    chk("restart_pc", pc, 32'h4);
    chk("restart_valid", valid_out, 1'b1);
    chk("restart_instr", instruction_out, I1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
